// File: rtl/frac_lut6_cfg_loader.sv
// Configuration sequencer for a column of frac_lut6 frames that share one
// serial config flip-flop chain. Host words arrive over valid/ready and are
// shifted LSB first onto the chain head, 66 bits (64 sram + 2 mode) per LUT.
//
// Handshake: a word transfers on a rising edge where cfg_valid_i and
// cfg_ready_o are both 1. cfg_ready_o is high only in FETCH and is pulled low
// combinationally in a cycle where abort_i is high, so an abort never races
// with an accepted word. The host may hold or drop valid freely; the loader
// never drops ready once it is raised except on abort.
module frac_lut6_cfg_loader #(
    parameter int NUM_LUTS  = 8,
    parameter int WORD_W    = 32,
    parameter int LUT_IDX_W = 3
) (
    input  logic                 prog_clk,
    input  logic                 prog_rst_n,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [WORD_W-1:0]    cfg_word_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    output logic                 ccff_head_o,
    output logic                 prog_en_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 aborted_o,
    output logic [LUT_IDX_W-1:0] lut_idx_o,
    output logic [1:0]           fsm_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [LUT_IDX_W-1:0] LAST_LUT = LUT_IDX_W'(NUM_LUTS - 1);

    state_t                 state, state_nxt;
    logic [WORD_W-1:0]      shreg, shreg_nxt;
    logic [5:0]             bits_left, bits_left_nxt;
    logic [1:0]             word_idx, word_idx_nxt;
    logic [LUT_IDX_W-1:0]   lut_idx, lut_idx_nxt;
    logic                   aborted, aborted_nxt;

    // State and datapath registers; reset leaves the chain itself untouched.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state     <= S_IDLE;
            shreg     <= '0;
            bits_left <= '0;
            word_idx  <= '0;
            lut_idx   <= '0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bits_left <= bits_left_nxt;
            word_idx  <= word_idx_nxt;
            lut_idx   <= lut_idx_nxt;
            aborted   <= aborted_nxt;
        end
    end

    // Next-state logic: fetch a word, shift it out, advance word/LUT counters.
    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        bits_left_nxt = bits_left;
        word_idx_nxt  = word_idx;
        lut_idx_nxt   = lut_idx;
        aborted_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt    = S_FETCH;
                    word_idx_nxt = '0;
                    lut_idx_nxt  = '0;
                end
            end
            S_FETCH: begin
                if (abort_i) begin
                    state_nxt    = S_IDLE;
                    aborted_nxt  = 1'b1;
                    word_idx_nxt = '0;
                    lut_idx_nxt  = '0;
                end else if (cfg_valid_i) begin
                    shreg_nxt     = cfg_word_i;
                    // The third word of a frame carries only the two mode bits.
                    bits_left_nxt = (word_idx == 2'd2) ? 6'd2 : 6'd32;
                    state_nxt     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort_i) begin
                    state_nxt    = S_IDLE;
                    aborted_nxt  = 1'b1;
                    word_idx_nxt = '0;
                    lut_idx_nxt  = '0;
                end else begin
                    shreg_nxt     = {1'b0, shreg[WORD_W-1:1]};
                    bits_left_nxt = bits_left - 6'd1;
                    if (bits_left == 6'd1) begin
                        if (word_idx != 2'd2) begin
                            word_idx_nxt = word_idx + 2'd1;
                            state_nxt    = S_FETCH;
                        end else if (lut_idx != LAST_LUT) begin
                            word_idx_nxt = '0;
                            lut_idx_nxt  = lut_idx + 1'b1;
                            state_nxt    = S_FETCH;
                        end else begin
                            state_nxt = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_nxt    = S_IDLE;
                word_idx_nxt = '0;
                lut_idx_nxt  = '0;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status and chain outputs decoded from the registered state.
    always_comb begin
        cfg_ready_o = (state == S_FETCH) && !abort_i;
        prog_en_o   = (state == S_SHIFT);
        ccff_head_o = (state == S_SHIFT) && shreg[0];
        busy_o      = (state != S_IDLE);
        done_o      = (state == S_DONE);
        aborted_o   = aborted;
        lut_idx_o   = lut_idx;
        fsm_state_o = state;
    end

endmodule

// File: tb/tb_frac_lut6_cfg_loader.sv
// Directed-plus-random bench for frac_lut6_cfg_loader with a two-LUT column.
module tb_frac_lut6_cfg_loader;

    localparam int NUM_LUTS = 2;
    localparam int NW       = 3 * NUM_LUTS;

    // ---------------- clock / reset / DUT ----------------
    logic        prog_clk    = 1'b0;
    logic        prog_rst_n  = 1'b0;
    logic        start_i     = 1'b0;
    logic        abort_i     = 1'b0;
    logic [31:0] cfg_word_i  = '0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o, ccff_head_o, prog_en_o, busy_o, done_o, aborted_o;
    logic [2:0]  lut_idx_o;
    logic [1:0]  fsm_state_o;

    always #5 prog_clk = ~prog_clk;

    frac_lut6_cfg_loader #(.NUM_LUTS(NUM_LUTS), .WORD_W(32), .LUT_IDX_W(3)) dut (
        .prog_clk    (prog_clk),
        .prog_rst_n  (prog_rst_n),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .cfg_word_i  (cfg_word_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .ccff_head_o (ccff_head_o),
        .prog_en_o   (prog_en_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .aborted_o   (aborted_o),
        .lut_idx_o   (lut_idx_o),
        .fsm_state_o (fsm_state_o)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] words [NW];
    logic [0:0]  exp_q [$];
    logic [0:0]  got_q [$];
    int exp_hs [$];
    int hs_t   [$];
    int hs_lut [$];
    int exp_done;
    int done_t, abort_t, prog_cnt, done_cnt, abort_cnt, head_bad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbits(input int k);
        return (k % 3 == 2) ? 2 : 32;
    endfunction

    // Expected bit stream and handshake timing from word list and one host stall.
    task automatic build_expect(input int stall_idx, input int stall_len);
        int ready_t;
        logic [31:0] w;
        exp_q.delete();
        exp_hs.delete();
        ready_t = 1;
        for (int k = 0; k < NW; k++) begin
            int hs;
            hs = ready_t + ((k == stall_idx) ? stall_len : 0);
            exp_hs.push_back(hs);
            ready_t = hs + nbits(k) + 1;
            w = words[k];
            for (int b = 0; b < nbits(k); b++) exp_q.push_back(w[b]);
        end
        exp_done = ready_t;
    endtask

    // ---------------- driver + monitor ----------------
    // Cycle 0 is the cycle start_i is driven. Inputs change 1ns after the
    // rising edge; outputs are sampled on the falling edge.
    task automatic run_load(input int stall_idx, input int stall_len, input int abort_cyc,
                            input int start_cyc2, input int rst_cyc);
        int  w;
        int  stall_left;
        int  t;
        bit  fin;
        w = 0; stall_left = stall_len; fin = 0;
        done_t = -1; abort_t = -1; prog_cnt = 0; done_cnt = 0; abort_cnt = 0; head_bad = 0;
        hs_t.delete(); hs_lut.delete(); got_q.delete();
        for (t = 0; t < 600 && !fin; t++) begin
            @(posedge prog_clk); #1;
            start_i     = (t == 0) || (t == start_cyc2);
            abort_i     = (t == abort_cyc);
            cfg_valid_i = (w < NW) && !(w == stall_idx && stall_left > 0);
            cfg_word_i  = (w < NW) ? words[w] : 32'hDEAD_BEEF;
            if (t == rst_cyc) begin
                #2 prog_rst_n = 1'b0;
                #1;
                check("rst_ready",   cfg_ready_o, 0);
                check("rst_prog_en", prog_en_o,   0);
                check("rst_head",    ccff_head_o, 0);
                check("rst_busy",    busy_o,      0);
                check("rst_done",    done_o,      0);
                check("rst_aborted", aborted_o,   0);
                check("rst_lut_idx", lut_idx_o,   0);
                fin = 1;
            end else begin
                @(negedge prog_clk);
                if (cfg_valid_i && cfg_ready_o) begin
                    hs_t.push_back(t);
                    hs_lut.push_back(int'(lut_idx_o));
                    w++;
                end else if (w == stall_idx && stall_left > 0 && cfg_ready_o) begin
                    stall_left--;
                end
                if (prog_en_o) begin
                    got_q.push_back(ccff_head_o);
                    prog_cnt++;
                end else if (ccff_head_o !== 1'b0) begin
                    head_bad++;
                end
                if (abort_cyc >= 0 && t == abort_cyc + 1) begin
                    check("abort_prog_en", prog_en_o,   0);
                    check("abort_busy",    busy_o,      0);
                    check("abort_ready",   cfg_ready_o, 0);
                    check("abort_pulse",   aborted_o,   1);
                end
                if (done_o) begin
                    done_cnt++; done_t = t; fin = 1;
                    check("done_lut_idx_hold", lut_idx_o, NUM_LUTS - 1);
                end
                if (aborted_o) begin
                    abort_cnt++; abort_t = t; fin = 1;
                end
            end
        end
        start_i = 1'b0; abort_i = 1'b0; cfg_valid_i = 1'b0;
        if (!fin) check("load_timeout", 0, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge prog_clk);
            if (done_o)    done_cnt++;
            if (aborted_o) abort_cnt++;
            if (prog_en_o) prog_cnt++;
            if (k == 0 && done_t >= 0) begin
                check("idle_lut_idx_clear", lut_idx_o, 0);
                check("idle_after_done",    busy_o,    0);
            end
        end
    endtask

    // Compare a completed load against the model.
    task automatic compare_run(input string tag);
        int bad_hs, bad_bits;
        bad_hs = 0; bad_bits = 0;
        check({tag, "_hs_count"}, hs_t.size(), NW);
        for (int k = 0; k < NW && k < hs_t.size(); k++) begin
            if (hs_t[k] != exp_hs[k] || hs_lut[k] != k / 3) bad_hs++;
        end
        check({tag, "_hs_timing_lut"}, bad_hs, 0);
        check({tag, "_prog_en_cycles"}, prog_cnt, 66 * NUM_LUTS);
        check({tag, "_stream_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) bad_bits++;
        end
        check({tag, "_stream_bits"}, bad_bits, 0);
        check({tag, "_done_cycle"}, done_t, exp_done);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_abort_pulses"}, abort_cnt, 0);
        check({tag, "_head_idle_zero"}, head_bad, 0);
    endtask

    task automatic idle_valid_probe(input string tag);
        cfg_valid_i = 1'b1;
        cfg_word_i  = $urandom;
        for (int k = 0; k < 5; k++) begin
            @(negedge prog_clk);
            check({tag, "_ready"}, cfg_ready_o, 0);
            check({tag, "_busy"},  busy_o,      0);
        end
        cfg_valid_i = 1'b0;
    endtask

    task automatic rand_words();
        for (int k = 0; k < NW; k++) words[k] = $urandom;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int sidx, slen;
        repeat (3) @(negedge prog_clk);
        check("reset_ready",   cfg_ready_o, 0);
        check("reset_head",    ccff_head_o, 0);
        check("reset_prog_en", prog_en_o,   0);
        check("reset_busy",    busy_o,      0);
        check("reset_done",    done_o,      0);
        check("reset_aborted", aborted_o,   0);
        check("reset_lut_idx", lut_idx_o,   0);
        check("reset_state",   fsm_state_o, 0);
        prog_rst_n = 1'b1;
        idle_valid_probe("idle_valid");

        // Directed words, valid always high.
        words = '{32'hA5A5A5A5, 32'h0000FFFF, 32'h2, 32'h1, 32'h0, 32'h3};
        build_expect(-1, 0);
        run_load(-1, 0, -1, -1, -1);
        compare_run("directed");

        // Ten-cycle host stall before word1 of LUT0.
        rand_words();
        build_expect(1, 10);
        run_load(1, 10, -1, -1, -1);
        compare_run("stall10");
        check("stall10_delay", exp_done, 149);

        // Stray start during SHIFT; mode word with upper bits set.
        rand_words();
        words[2] = 32'hFFFFFFFC;
        build_expect(-1, 0);
        run_load(-1, 0, -1, 10, -1);
        compare_run("start_in_shift");

        // Random stalls at random positions.
        for (int r = 0; r < 3; r++) begin
            rand_words();
            sidx = $urandom_range(0, NW - 1);
            slen = $urandom_range(1, 20);
            build_expect(sidx, slen);
            run_load(sidx, slen, -1, -1, -1);
            compare_run("rand_stall");
        end

        // Abort mid-shift of word0, then a clean restart.
        rand_words();
        run_load(-1, 0, 20, -1, -1);
        check("abort_cycle",       abort_t,   21);
        check("abort_pulse_count", abort_cnt, 1);
        check("abort_no_done",     done_cnt,  0);
        rand_words();
        build_expect(-1, 0);
        run_load(-1, 0, -1, -1, -1);
        compare_run("after_abort");

        // Asynchronous reset mid-shift.
        rand_words();
        run_load(-1, 0, -1, -1, 50);
        repeat (2) @(negedge prog_clk);
        prog_rst_n = 1'b1;
        idle_valid_probe("post_reset");
        check("post_reset_state", fsm_state_o, 0);
        rand_words();
        build_expect(-1, 0);
        run_load(-1, 0, -1, -1, -1);
        compare_run("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
